fft_peak_analyzer: RTL

- Sits downstream of the 16-point FFT block and is the consumer end of its parallel result interface: fft_valid plus fft_d0..fft_d15.
- Captures one frame of 16 complex bins on fft_valid and computes |X|^2 = re^2 + im^2 for each bin, one bin per clock.
- Reports the index of the strongest bin (freq) and its magnitude, with a one-cycle done pulse.
- Sustains back-to-back frames at the FFT's 16-cycle cadence.

---
 rtl/fft_peak_analyzer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fft_peak_analyzer.sv
// Peak-bin finder for one 16-bin FFT frame: captures the frame, squares one bin per
// cycle, and reports the index and |X|^2 of the strongest bin with a done pulse.
module fft_peak_analyzer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MAG_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fft_valid,
   input  logic [DATA_W-1:0] fft_d0,
   input  logic [DATA_W-1:0] fft_d1,
   input  logic [DATA_W-1:0] fft_d2,
   input  logic [DATA_W-1:0] fft_d3,
   input  logic [DATA_W-1:0] fft_d4,
   input  logic [DATA_W-1:0] fft_d5,
   input  logic [DATA_W-1:0] fft_d6,
   input  logic [DATA_W-1:0] fft_d7,
   input  logic [DATA_W-1:0] fft_d8,
   input  logic [DATA_W-1:0] fft_d9,
   input  logic [DATA_W-1:0] fft_d10,
   input  logic [DATA_W-1:0] fft_d11,
   input  logic [DATA_W-1:0] fft_d12,
   input  logic [DATA_W-1:0] fft_d13,
   input  logic [DATA_W-1:0] fft_d14,
   input  logic [DATA_W-1:0] fft_d15,
   output logic              done,
   output logic [3:0]        freq,
   output logic [MAG_W-1:0]  max_mag,
   output logic              overrun
);

   localparam int unsigned HALF_W = DATA_W / 2;
   localparam int unsigned NBINS  = 16;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [DATA_W-1:0] bank_q [NBINS];
   logic              load_c;
   logic [MAG_W-1:0]  run_max_q, run_max_d;
   logic [3:0]        run_idx_q, run_idx_d;
   logic              done_d, overrun_d;
   logic [3:0]        freq_d;
   logic [MAG_W-1:0]  max_mag_d;

   logic [DATA_W-1:0] din [NBINS];
   assign din[0]  = fft_d0;
   assign din[1]  = fft_d1;
   assign din[2]  = fft_d2;
   assign din[3]  = fft_d3;
   assign din[4]  = fft_d4;
   assign din[5]  = fft_d5;
   assign din[6]  = fft_d6;
   assign din[7]  = fft_d7;
   assign din[8]  = fft_d8;
   assign din[9]  = fft_d9;
   assign din[10] = fft_d10;
   assign din[11] = fft_d11;
   assign din[12] = fft_d12;
   assign din[13] = fft_d13;
   assign din[14] = fft_d14;
   assign din[15] = fft_d15;

   // Single shared squarer pair on the bin selected by idx.
   logic [DATA_W-1:0]        sel_c;
   logic signed [HALF_W-1:0] re_c, im_c;
   logic signed [DATA_W-1:0] re_sq_c, im_sq_c;
   logic [MAG_W-1:0]         mag_c;

   always_comb begin
      sel_c   = bank_q[idx_q];
      re_c    = sel_c[DATA_W-1:HALF_W];
      im_c    = sel_c[HALF_W-1:0];
      re_sq_c = DATA_W'(re_c) * DATA_W'(re_c);
      im_sq_c = DATA_W'(im_c) * DATA_W'(im_c);
      mag_c   = MAG_W'($unsigned(re_sq_c)) + MAG_W'($unsigned(im_sq_c));
   end

   // Next-state, peak tracking and output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      load_c    = 1'b0;
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
      freq_d    = freq;
      max_mag_d = max_mag;

      case (state_q)
         S_IDLE: begin
            if (fft_valid) begin
               load_c  = 1'b1;
               idx_d   = 4'd0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (idx_q == 4'd0 || mag_c > run_max_q) begin
               run_max_d = mag_c;
               run_idx_d = idx_q;
            end
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
               done_d    = 1'b1;
               freq_d    = run_idx_d;
               max_mag_d = run_max_d;
               // A frame arriving in the last cycle chains on without a gap.
               if (fft_valid) begin
                  load_c  = 1'b1;
                  idx_d   = 4'd0;
                  state_d = S_CALC;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (fft_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= 4'd0;
         run_max_q <= '0;
         run_idx_q <= 4'd0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         freq      <= 4'd0;
         max_mag   <= '0;
         for (int i = 0; i < int'(NBINS); i++) bank_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         done      <= done_d;
         overrun   <= overrun_d;
         freq      <= freq_d;
         max_mag   <= max_mag_d;
         if (load_c) begin
            for (int i = 0; i < int'(NBINS); i++) bank_q[i] <= din[i];
         end
      end
   end

endmodule
